// File: rtl/mpeg_splitter.sv
// mpeg_splitter: splits an MPEG program stream into a video elementary stream and a
// byte stream holding everything else (pack/system headers, PES headers, other streams).
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   clk_en           global clock enable; when low all state and outputs hold
//   mpeg_in          program-stream byte, valid the cycle after mpeg_rd
//   mpeg_empty       upstream FIFO empty
//   mpeg_rd          upstream FIFO read strobe (combinational)
//   vid_out, vid_wr  video byte and write strobe (registered)
//   vid_afull        video FIFO almost full
//   misc_out, misc_wr non-video byte and write strobe (registered)
//   misc_afull       misc FIFO almost full
//   vid_bytes        saturating count of vid_wr pulses, only when
//                    MPEG_SPLITTER_VID_COUNT_EN is defined
module mpeg_splitter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [7:0]  mpeg_in,
    input  logic        mpeg_empty,
    output logic        mpeg_rd,
    output logic [7:0]  vid_out,
    output logic        vid_wr,
    input  logic        vid_afull,
    output logic [7:0]  misc_out,
    output logic        misc_wr,
    input  logic        misc_afull
`ifdef MPEG_SPLITTER_VID_COUNT_EN
    ,
    output logic [31:0] vid_bytes
`endif
);

    typedef enum logic [3:0] {
        StNonPack        = 4'd0,
        StNonVideoSize0  = 4'd1,
        StNonVideoSize1  = 4'd2,
        StNonVideoStream = 4'd3,
        StVideoSize0     = 4'd4,
        StVideoSize1     = 4'd5,
        StVideoTsHeader  = 4'd6,
        StVideoMisc      = 4'd7,
        StVideoTimestamp = 4'd8,
        StVideoStream    = 4'd9
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] header_q, header_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [7:0]  ts_cnt_q, ts_cnt_d;
    logic        in_ready_q, in_ready_d;
    logic [7:0]  vid_out_q, vid_out_d;
    logic [7:0]  misc_out_q, misc_out_d;
    logic        vid_wr_q, vid_wr_d;
    logic        misc_wr_q, misc_wr_d;
    logic        to_vid;
    logic        dst_afull;
    logic        consume;

    assign to_vid    = (state_q == StVideoStream);
    assign dst_afull = to_vid ? vid_afull : misc_afull;
    assign consume   = clk_en & in_ready_q & ~dst_afull;
    assign mpeg_rd   = clk_en & ~mpeg_empty & (~in_ready_q | consume);

    always_comb begin
        state_d    = state_q;
        header_d   = header_q;
        pkt_cnt_d  = pkt_cnt_q;
        ts_cnt_d   = ts_cnt_q;
        // A read refills the holding slot; otherwise it empties only when consumed.
        in_ready_d = mpeg_rd | (in_ready_q & ~consume);
        vid_wr_d   = consume & to_vid;
        misc_wr_d  = consume & ~to_vid;
        vid_out_d  = (consume & to_vid) ? mpeg_in : vid_out_q;
        misc_out_d = (consume & ~to_vid) ? mpeg_in : misc_out_q;

        if (consume) begin
            header_d = {header_q[15:0], mpeg_in};
            case (state_q)
                StNonPack: begin
                    if (header_q == 24'h000001) begin
                        if (mpeg_in[7:4] == 4'hE) begin
                            state_d = StVideoSize0;
                        end else if (mpeg_in == 8'hBA) begin
                            // Pack header: fixed 8 trailing bytes.
                            state_d   = StNonVideoStream;
                            pkt_cnt_d = 16'd8;
                        end else begin
                            state_d = StNonVideoSize0;
                        end
                    end
                end
                StNonVideoSize0: begin
                    pkt_cnt_d = {mpeg_in, pkt_cnt_q[7:0]};
                    state_d   = StNonVideoSize1;
                end
                StNonVideoSize1: begin
                    pkt_cnt_d = {pkt_cnt_q[15:8], mpeg_in};
                    state_d   = ({pkt_cnt_q[15:8], mpeg_in} == 16'd0) ? StNonPack
                                                                       : StNonVideoStream;
                end
                StVideoSize0: begin
                    pkt_cnt_d = {mpeg_in, pkt_cnt_q[7:0]};
                    state_d   = StVideoSize1;
                end
                StVideoSize1: begin
                    pkt_cnt_d = {pkt_cnt_q[15:8], mpeg_in};
                    state_d   = ({pkt_cnt_q[15:8], mpeg_in} == 16'd0) ? StNonPack
                                                                       : StVideoTsHeader;
                end
                default: begin
                    // Payload-counted states; the length exit wins over any sub-state.
                    pkt_cnt_d = pkt_cnt_q - 16'd1;
                    if (state_q == StVideoTimestamp) begin
                        ts_cnt_d = ts_cnt_q - 8'd1;
                    end
                    if (pkt_cnt_q == 16'd1) begin
                        state_d = StNonPack;
                    end else begin
                        case (state_q)
                            StVideoTsHeader: begin
                                if (mpeg_in == 8'hFF) begin
                                    state_d = StVideoTsHeader;
                                end else if (mpeg_in[7:6] == 2'b01) begin
                                    state_d = StVideoMisc;
                                end else if (mpeg_in[5:4] == 2'b00) begin
                                    state_d = StVideoStream;
                                end else if (mpeg_in[5:4] == 2'b10) begin
                                    state_d  = StVideoTimestamp;
                                    ts_cnt_d = 8'd4;
                                end else if (mpeg_in[5:4] == 2'b11) begin
                                    state_d  = StVideoTimestamp;
                                    ts_cnt_d = 8'd9;
                                end
                            end
                            StVideoMisc: state_d = StVideoTsHeader;
                            StVideoTimestamp: begin
                                if (ts_cnt_q == 8'd1) begin
                                    state_d = StVideoStream;
                                end
                            end
                            default: state_d = state_q;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StNonPack;
            header_q   <= 24'hFFFFFF;
            pkt_cnt_q  <= 16'd0;
            ts_cnt_q   <= 8'd0;
            in_ready_q <= 1'b0;
            vid_out_q  <= 8'h00;
            misc_out_q <= 8'h00;
            vid_wr_q   <= 1'b0;
            misc_wr_q  <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            header_q   <= header_d;
            pkt_cnt_q  <= pkt_cnt_d;
            ts_cnt_q   <= ts_cnt_d;
            in_ready_q <= in_ready_d;
            vid_out_q  <= vid_out_d;
            misc_out_q <= misc_out_d;
            vid_wr_q   <= vid_wr_d;
            misc_wr_q  <= misc_wr_d;
        end
    end

    assign vid_out  = vid_out_q;
    assign vid_wr   = vid_wr_q;
    assign misc_out = misc_out_q;
    assign misc_wr  = misc_wr_q;

`ifdef MPEG_SPLITTER_VID_COUNT_EN
    logic [31:0] vid_cnt_q, vid_cnt_d;

    // Counts alongside vid_wr_d so the count already includes the pulse on vid_wr.
    assign vid_cnt_d = (vid_wr_d && vid_cnt_q != 32'hFFFFFFFF) ? vid_cnt_q + 32'd1 : vid_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vid_cnt_q <= 32'd0;
        end else if (clk_en) begin
            vid_cnt_q <= vid_cnt_d;
        end
    end

    assign vid_bytes = vid_cnt_q;
`endif

endmodule

// File: tb/tb_mpeg_splitter.sv
// Self-checking bench for mpeg_splitter: an upstream FIFO model feeds byte streams,
// expected video/misc bytes are queued as they are pushed and compared on each wr pulse.
module tb_mpeg_splitter;

    logic       clk = 1'b0;
    logic       rst, clk_en, mpeg_empty, mpeg_rd;
    logic       vid_wr, vid_afull, misc_wr, misc_afull;
    logic [7:0] mpeg_in, vid_out, misc_out;
`ifdef MPEG_SPLITTER_VID_COUNT_EN
    logic [31:0] vid_bytes;
`endif

    always #5 clk = ~clk;

    mpeg_splitter dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .mpeg_in    (mpeg_in),
        .mpeg_empty (mpeg_empty),
        .mpeg_rd    (mpeg_rd),
        .vid_out    (vid_out),
        .vid_wr     (vid_wr),
        .vid_afull  (vid_afull),
        .misc_out   (misc_out),
        .misc_wr    (misc_wr),
        .misc_afull (misc_afull)
`ifdef MPEG_SPLITTER_VID_COUNT_EN
        ,
        .vid_bytes  (vid_bytes)
`endif
    );

    typedef struct packed {
        logic [191:0] data;   // first byte in the most significant used position
        logic [23:0]  vmask;  // bit i set: byte i goes to video
        logic [4:0]   n;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] src_q[$];
    logic [7:0] exp_vid[$];
    logic [7:0] exp_misc[$];
    int         checks = 0;
    int         failures = 0;
    int         vid_pulses = 0;
    bit         sb_en = 1'b0;
    bit         rand_bp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit v);
        src_q.push_back(b);
        if (v) exp_vid.push_back(b);
        else exp_misc.push_back(b);
        mpeg_empty = 1'b0;
    endtask

    // One clock: model the upstream FIFO and score any write pulse.
    task automatic tick();
        logic rd, en;
        @(negedge clk);
        rd = mpeg_rd;
        en = clk_en;
        @(posedge clk);
        #1;
        if (rd) begin
            if (src_q.size() > 0) begin
                mpeg_in = src_q.pop_front();
            end else begin
                checks++;
                failures++;
                $display("FAIL rd_when_empty: got mpeg_rd=1, expected 0 with FIFO empty");
            end
        end
        mpeg_empty = (src_q.size() == 0);
        if (rand_bp) begin
            vid_afull  = ($urandom_range(0, 3) == 0);
            misc_afull = ($urandom_range(0, 3) == 0);
        end
        if (sb_en && en) begin
            if (vid_wr) begin
                vid_pulses++;
                if (exp_vid.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL vid_unexpected: got byte %0h, expected no write", vid_out);
                end else begin
                    check("vid_data", {24'h0, vid_out}, {24'h0, exp_vid.pop_front()});
                end
            end
            if (misc_wr) begin
                if (exp_misc.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL misc_unexpected: got byte %0h, expected no write", misc_out);
                end else begin
                    check("misc_data", {24'h0, misc_out}, {24'h0, exp_misc.pop_front()});
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((src_q.size() > 0 || exp_vid.size() > 0 || exp_misc.size() > 0) && n < 400) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check({name, "_vid_left"}, exp_vid.size(), 0);
        check({name, "_misc_left"}, exp_misc.size(), 0);
    endtask

    task automatic wait_vid(input string name);
        int n;
        n = 0;
        while (!vid_wr && n < 100) begin
            tick();
            n++;
        end
        check({name, "_vid_seen"}, {31'h0, vid_wr}, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_vid_wr"}, {31'h0, vid_wr}, 0);
        check({name, "_misc_wr"}, {31'h0, misc_wr}, 0);
        check({name, "_vid_out"}, {24'h0, vid_out}, 0);
        check({name, "_misc_out"}, {24'h0, misc_out}, 0);
        check({name, "_state"}, {28'h0, dut.state_q}, 0);
        check({name, "_header"}, {8'h0, dut.header_q}, 32'h00FFFFFF);
        check({name, "_pkt_cnt"}, {16'h0, dut.pkt_cnt_q}, 0);
        check({name, "_ts_cnt"}, {24'h0, dut.ts_cnt_q}, 0);
        check({name, "_in_ready"}, {31'h0, dut.in_ready_q}, 0);
`ifdef MPEG_SPLITTER_VID_COUNT_EN
        check({name, "_vid_bytes"}, vid_bytes, 0);
`endif
    endtask

    initial begin
        int n;
        vecs[0] = '{data: 192'({8'h00, 8'h00, 8'h01, 8'hBA, 8'h11, 8'h22, 8'h33, 8'h44,
                                8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00, 8'h01, 8'hBB,
                                8'h00, 8'h02, 8'hAA, 8'hBB}),
                    vmask: 24'h000000, n: 5'd20};
        vecs[1] = '{data: 192'({8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h08, 8'h21, 8'h11,
                                8'h22, 8'h33, 8'h44, 8'h55, 8'hD0, 8'hD1}),
                    vmask: 24'h003800, n: 5'd14};
        vecs[2] = '{data: 192'({8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h05, 8'hFF, 8'hFF,
                                8'h0F, 8'hA0, 8'hA1}),
                    vmask: 24'h000600, n: 5'd11};
        vecs[3] = '{data: 192'({8'h00, 8'h00, 8'h01, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h01, 8'hE0, 8'h00, 8'h03, 8'h0F, 8'h5A, 8'h5B}),
                    vmask: 24'h006000, n: 5'd15};
        vecs[4] = '{data: 192'({8'h00, 8'h00, 8'h01, 8'hE5, 8'h00, 8'h0E, 8'h40, 8'h7E,
                                8'h31, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                8'h08, 8'h09, 8'hC1, 8'hC2}),
                    vmask: 24'h0C0000, n: 5'd20};
        vecs[5] = '{data: 192'({8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h02, 8'hFF, 8'hFF,
                                8'h00, 8'h00, 8'h01, 8'hBD, 8'h00, 8'h01, 8'h77}),
                    vmask: 24'h000000, n: 5'd15};

        rst        = 1'b0;
        clk_en     = 1'b0;
        mpeg_in    = 8'h00;
        mpeg_empty = 1'b1;
        vid_afull  = 1'b0;
        misc_afull = 1'b0;

        // Reset applies even with clk_en low.
        repeat (3) tick();
        check_reset_outputs("reset");
        check("reset_rd", {31'h0, mpeg_rd}, 0);
        rst    = 1'b1;
        clk_en = 1'b1;
        sb_en  = 1'b1;

        // Table-driven streams with random back-pressure on both FIFOs.
        rand_bp = 1'b1;
        for (int v = 0; v < 6; v++) begin
            n = int'(vecs[v].n);
            for (int i = 0; i < n; i++) begin
                push(vecs[v].data[8*(n-1-i) +: 8], vecs[v].vmask[i]);
            end
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_state", v), {28'h0, dut.state_q}, 0);
        end
        rand_bp    = 1'b0;
        vid_afull  = 1'b0;
        misc_afull = 1'b0;

        // Back-pressure: misc held full during headers, video held full for 20 cycles.
        misc_afull = 1'b1;
        push(8'h00, 0); push(8'h00, 0); push(8'h01, 0); push(8'hE0, 0);
        push(8'h00, 0); push(8'h06, 0); push(8'h0F, 0);
        push(8'hB1, 1); push(8'hB2, 1); push(8'hB3, 1); push(8'hB4, 1); push(8'hB5, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k >= 1) begin
                check("misc_bp_wr", {31'h0, misc_wr}, 0);
                check("misc_bp_rd", {31'h0, mpeg_rd}, 0);
            end
        end
        misc_afull = 1'b0;
        wait_vid("bp");
        vid_afull = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k >= 1) begin
                check("vid_bp_vid_wr", {31'h0, vid_wr}, 0);
                check("vid_bp_misc_wr", {31'h0, misc_wr}, 0);
            end
            if (k >= 2) check("vid_bp_rd", {31'h0, mpeg_rd}, 0);
        end
        vid_afull = 1'b0;
        drain("bp");

        // Clock enable low mid-stream: nothing is read, then the stream completes.
        n = int'(vecs[2].n);
        for (int i = 0; i < n; i++) push(vecs[2].data[8*(n-1-i) +: 8], vecs[2].vmask[i]);
        repeat (6) tick();
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("clken_rd", {31'h0, mpeg_rd}, 0);
        end
        clk_en = 1'b1;
        drain("clken");

        // Reset in the middle of video payload.
        push(8'h00, 0); push(8'h00, 0); push(8'h01, 0); push(8'hE0, 0);
        push(8'h00, 0); push(8'h08, 0); push(8'h0F, 0);
        for (int i = 0; i < 7; i++) push(8'hC0 + 8'(i), 1);
        wait_vid("midrst");
        tick();
        sb_en = 1'b0;
        src_q.delete();
        exp_vid.delete();
        exp_misc.delete();
        mpeg_empty = 1'b1;
        rst = 1'b0;
        repeat (2) tick();
        check_reset_outputs("midrst");
        rst        = 1'b1;
        sb_en      = 1'b1;
        vid_pulses = 0;
        push(8'hA5, 0); push(8'hA6, 0); push(8'h00, 0); push(8'h00, 0); push(8'h01, 0);
        push(8'hE0, 0); push(8'h00, 0); push(8'h02, 0); push(8'h0F, 0); push(8'h99, 1);
        drain("after_rst");
        check("after_rst_state", {28'h0, dut.state_q}, 0);
`ifdef MPEG_SPLITTER_VID_COUNT_EN
        check("vid_bytes_count", vid_bytes, vid_pulses);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
